// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-byte holding register and a fractional
// accumulator baud tick shared in form with uart_receiver.
module uart_transmitter #(
    parameter int BIT_DEPTH  = 11,
    parameter int ADDER      = 170,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       send,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int                   SUB_W     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [BIT_DEPTH:0]   ADDER_EXT = (BIT_DEPTH + 1)'(ADDER);
    localparam logic [SUB_W-1:0]     SUB_LAST  = SUB_W'(OVERSAMPLE - 1);
    localparam logic [SUB_W-1:0]     SUB_ONE   = SUB_W'(1);
    localparam logic [2:0]           STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [BIT_DEPTH-1:0] acc_r;
    logic                 tick_r;
    logic [BIT_DEPTH:0]   sum_s;

    state_t               state_r, state_s;
    logic [SUB_W-1:0]     sub_r, sub_s;
    logic [2:0]           bit_r, bit_s;
    logic [7:0]           shift_r, shift_s;
    logic [7:0]           hold_r, hold_s;
    logic                 ready_r, ready_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 tx_r, tx_s;
    logic                 load_s;
    logic                 accept_s;
    logic                 last_sub_s;

    // Baud accumulator sum; the carry out of the top bit is the next tick.
    always_comb begin
        sum_s = {1'b0, acc_r} + ADDER_EXT;
    end

    // Free-running oversample tick generator.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            acc_r  <= sum_s[BIT_DEPTH-1:0];
            tick_r <= sum_s[BIT_DEPTH];
        end
    end

    // Next-state, handshake and line-level decode.
    always_comb begin
        state_s    = state_r;
        sub_s      = sub_r;
        bit_s      = bit_r;
        shift_s    = shift_r;
        hold_s     = hold_r;
        ready_s    = ready_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        tx_s       = tx_r;
        load_s     = 1'b0;
        accept_s   = send && ready_r;
        last_sub_s = tick_r && (sub_r == SUB_LAST);

        case (state_r)
            ST_IDLE: begin
                tx_s   = 1'b1;
                busy_s = 1'b0;
                // The load tick is already the first tick of the start bit.
                if (tick_r && !ready_r) begin
                    load_s  = 1'b1;
                    state_s = ST_START;
                    sub_s   = '0;
                    bit_s   = 3'd0;
                    tx_s    = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (last_sub_s) begin
                    state_s = ST_DATA;
                    sub_s   = '0;
                    bit_s   = 3'd0;
                    tx_s    = shift_r[0];
                end else if (tick_r) begin
                    sub_s = sub_r + SUB_ONE;
                end else begin
                    sub_s = sub_r;
                end
            end
            ST_DATA: begin
                if (last_sub_s) begin
                    sub_s = '0;
                    if (bit_r == 3'd7) begin
                        state_s = ST_STOP;
                        bit_s   = 3'd0;
                        tx_s    = 1'b1;
                    end else begin
                        bit_s = bit_r + 3'd1;
                        tx_s  = shift_r[bit_r + 3'd1];
                    end
                end else if (tick_r) begin
                    sub_s = sub_r + SUB_ONE;
                end else begin
                    sub_s = sub_r;
                end
            end
            ST_STOP: begin
                if (last_sub_s) begin
                    sub_s = '0;
                    if (bit_r == STOP_LAST) begin
                        done_s = 1'b1;
                        bit_s  = 3'd0;
                        // A queued byte follows with no idle gap.
                        if (!ready_r) begin
                            load_s  = 1'b1;
                            state_s = ST_START;
                            tx_s    = 1'b0;
                            busy_s  = 1'b1;
                        end else begin
                            state_s = ST_IDLE;
                            tx_s    = 1'b1;
                            busy_s  = 1'b0;
                        end
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else if (tick_r) begin
                    sub_s = sub_r + SUB_ONE;
                end else begin
                    sub_s = sub_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                sub_s   = '0;
                bit_s   = 3'd0;
                tx_s    = 1'b1;
                busy_s  = 1'b0;
            end
        endcase

        // Load and accept are exclusive: load needs ready low, accept needs it high.
        if (load_s) begin
            shift_s = hold_r;
            ready_s = 1'b1;
        end else if (accept_s) begin
            hold_s  = data;
            ready_s = 1'b0;
        end else begin
            ready_s = ready_r;
        end
    end

    // FSM, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sub_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            hold_r  <= 8'h00;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_s;
            sub_r   <= sub_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            hold_r  <= hold_s;
            ready_r <= ready_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            tx_r    <= tx_s;
        end
    end

    assign ready = ready_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign tx    = tx_r;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: tick-per-clk frames, back-to-back,
// reset abort, two stop bits, and a slow-ADDER mid-bit sampling decoder.
module tb_uart_transmitter;

    logic clk;
    int   tests;
    int   fails;

    logic       a_rst, a_send, a_ready, a_busy, a_done, a_tx;
    logic [7:0] a_data;
    logic       b_rst, b_send, b_ready, b_busy, b_done, b_tx;
    logic [7:0] b_data;
    logic       c_rst, c_send, c_ready, c_busy, c_done, c_tx;
    logic [7:0] c_data;

    uart_transmitter #(.BIT_DEPTH(11), .ADDER(2048), .OVERSAMPLE(16), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(a_rst), .data(a_data), .send(a_send),
        .ready(a_ready), .busy(a_busy), .done(a_done), .tx(a_tx)
    );

    uart_transmitter #(.BIT_DEPTH(11), .ADDER(2048), .OVERSAMPLE(16), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(b_rst), .data(b_data), .send(b_send),
        .ready(b_ready), .busy(b_busy), .done(b_done), .tx(b_tx)
    );

    uart_transmitter #(.BIT_DEPTH(11), .ADDER(170), .OVERSAMPLE(16), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst(c_rst), .data(c_data), .send(c_send),
        .ready(c_ready), .busy(c_busy), .done(c_done), .tx(c_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_send = 1'b0; b_send = 1'b0; c_send = 1'b0;
        a_data = 8'h00; b_data = 8'h00; c_data = 8'h00;
        repeat (3) @(negedge clk);
        tests++; if (a_tx !== 1'b1)    begin fails++; $display("FAIL reset_tx got %b want 1", a_tx); end
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", a_ready); end
        tests++; if (a_busy !== 1'b0)  begin fails++; $display("FAIL reset_busy got %b want 0", a_busy); end
        tests++; if (a_done !== 1'b0)  begin fails++; $display("FAIL reset_done got %b want 0", a_done); end
        tests++; if (b_tx !== 1'b1 || c_tx !== 1'b1) begin fails++; $display("FAIL reset_tx_bc got %b%b want 11", b_tx, c_tx); end
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Sends one byte on dut_a and checks every clk of the 160-clk frame plus the done clk.
    task automatic test_single_frame(input logic [7:0] byte_v);
        logic [9:0] fr;
        logic       exp_tx;
        int         w;
        fr = {1'b1, byte_v, 1'b0};
        @(negedge clk);
        a_data = byte_v; a_send = 1'b1;
        @(negedge clk);
        a_send = 1'b0;
        w = 0;
        while (a_tx !== 1'b0 && w < 50) begin @(negedge clk); w++; end
        tests++;
        if (a_tx !== 1'b0) begin fails++; $display("FAIL frame_start byte=%h tx got %b want 0", byte_v, a_tx); end
        for (int c = 0; c <= 160; c++) begin
            exp_tx = (c < 160) ? fr[c / 16] : 1'b1;
            tests++; if (a_tx !== exp_tx) begin fails++; $display("FAIL frame_tx byte=%h c=%0d got %b want %b", byte_v, c, a_tx, exp_tx); end
            tests++; if (a_done !== (c == 160)) begin fails++; $display("FAIL frame_done byte=%h c=%0d got %b want %b", byte_v, c, a_done, (c == 160)); end
            tests++; if (a_busy !== (c < 160)) begin fails++; $display("FAIL frame_busy byte=%h c=%0d got %b want %b", byte_v, c, a_busy, (c < 160)); end
            @(negedge clk);
        end
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL frame_ready_after got %b want 1", a_ready); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] fr1, fr2;
        logic       exp_tx, exp_ready;
        int         w, done_cnt, stray;
        fr1 = {1'b1, 8'hA3, 1'b0};
        fr2 = {1'b1, 8'h0F, 1'b0};
        done_cnt = 0;
        @(negedge clk);
        a_data = 8'hA3; a_send = 1'b1;
        @(negedge clk);
        a_send = 1'b0;
        tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_after_accept got %b want 0", a_ready); end
        w = 0;
        while (a_tx !== 1'b0 && w < 50) begin @(negedge clk); w++; end
        tests++;
        if (a_tx !== 1'b0) begin fails++; $display("FAIL b2b_start tx got %b want 0", a_tx); end
        for (int c = 0; c <= 320; c++) begin
            if (c < 160)      exp_tx = fr1[c / 16];
            else if (c < 320) exp_tx = fr2[(c - 160) / 16];
            else              exp_tx = 1'b1;
            exp_ready = (c == 0) || (c >= 160);
            if (a_done === 1'b1) done_cnt++;
            tests++; if (a_tx !== exp_tx) begin fails++; $display("FAIL b2b_tx c=%0d got %b want %b", c, a_tx, exp_tx); end
            tests++; if (a_ready !== exp_ready) begin fails++; $display("FAIL b2b_ready c=%0d got %b want %b", c, a_ready, exp_ready); end
            tests++; if (a_done !== (c == 160 || c == 320)) begin fails++; $display("FAIL b2b_done c=%0d got %b want %b", c, a_done, (c == 160 || c == 320)); end
            tests++; if (a_busy !== (c < 320)) begin fails++; $display("FAIL b2b_busy c=%0d got %b want %b", c, a_busy, (c < 320)); end
            if (c == 0) begin a_data = 8'h0F; a_send = 1'b1; end
            if (c == 1) a_send = 1'b0;
            if (c == 5) begin a_data = 8'hEE; a_send = 1'b1; end
            if (c == 6) a_send = 1'b0;
            @(negedge clk);
        end
        stray = 0;
        for (int c = 0; c < 200; c++) begin
            if (a_tx !== 1'b1 || a_done !== 1'b0) stray++;
            @(negedge clk);
        end
        tests++; if (done_cnt != 2) begin fails++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
        tests++; if (stray != 0) begin fails++; $display("FAIL b2b_third_frame active clks got %0d want 0", stray); end
    endtask

    task automatic test_reset_mid_frame();
        int w, stray;
        @(negedge clk);
        a_data = 8'hFF; a_send = 1'b1;
        @(negedge clk);
        a_send = 1'b0;
        w = 0;
        while (a_tx !== 1'b0 && w < 50) begin @(negedge clk); w++; end
        tests++;
        if (a_tx !== 1'b0) begin fails++; $display("FAIL rst_mid_start tx got %b want 0", a_tx); end
        a_data = 8'h5A; a_send = 1'b1;
        @(negedge clk);
        a_send = 1'b0;
        repeat (39) @(negedge clk);
        tests++; if (a_tx !== 1'b1) begin fails++; $display("FAIL rst_mid_data_bit tx got %b want 1", a_tx); end
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        tests++; if (a_tx !== 1'b1)    begin fails++; $display("FAIL rst_mid_tx got %b want 1", a_tx); end
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got %b want 1", a_ready); end
        tests++; if (a_busy !== 1'b0)  begin fails++; $display("FAIL rst_mid_busy got %b want 0", a_busy); end
        tests++; if (a_done !== 1'b0)  begin fails++; $display("FAIL rst_mid_done got %b want 0", a_done); end
        stray = 0;
        for (int c = 0; c < 200; c++) begin
            if (a_tx !== 1'b1 || a_done !== 1'b0 || a_busy !== 1'b0) stray++;
            @(negedge clk);
        end
        tests++; if (stray != 0) begin fails++; $display("FAIL rst_mid_pending_dropped active clks got %0d want 0", stray); end
        test_single_frame(8'h00);
    endtask

    task automatic test_two_stop_bits();
        logic [10:0] fr;
        logic        exp_tx;
        int          w;
        fr = {2'b11, 8'h01, 1'b0};
        @(negedge clk);
        b_data = 8'h01; b_send = 1'b1;
        @(negedge clk);
        b_send = 1'b0;
        w = 0;
        while (b_tx !== 1'b0 && w < 50) begin @(negedge clk); w++; end
        tests++;
        if (b_tx !== 1'b0) begin fails++; $display("FAIL stop2_start tx got %b want 0", b_tx); end
        for (int c = 0; c <= 176; c++) begin
            exp_tx = (c < 176) ? fr[c / 16] : 1'b1;
            tests++; if (b_tx !== exp_tx) begin fails++; $display("FAIL stop2_tx c=%0d got %b want %b", c, b_tx, exp_tx); end
            tests++; if (b_done !== (c == 176)) begin fails++; $display("FAIL stop2_done c=%0d got %b want %b", c, b_done, (c == 176)); end
            tests++; if (b_busy !== (c < 176)) begin fails++; $display("FAIL stop2_busy c=%0d got %b want %b", c, b_busy, (c < 176)); end
            @(negedge clk);
        end
        tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL stop2_ready got %b want 1", b_ready); end
    endtask

    // Decodes dut_c's line by sampling at the nominal bit centres (192.75 clk per bit).
    task automatic test_loopback();
        logic [7:0] bytes_v [4];
        logic [7:0] rx;
        logic       start_ok, stop_ok;
        int         w, done_at, ctr;
        bytes_v[0] = 8'h00; bytes_v[1] = 8'hFF; bytes_v[2] = 8'h81; bytes_v[3] = 8'h3C;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            c_data = bytes_v[k]; c_send = 1'b1;
            @(negedge clk);
            c_send = 1'b0;
            w = 0;
            while (c_tx !== 1'b0 && w < 100) begin @(negedge clk); w++; end
            tests++;
            if (c_tx !== 1'b0) begin fails++; $display("FAIL loop_start byte=%h tx got %b want 0", bytes_v[k], c_tx); end
            rx = 8'h00; start_ok = 1'b0; stop_ok = 1'b0; done_at = -1;
            for (int c = 0; c < 2200 && done_at < 0; c++) begin
                for (int i = 0; i < 10; i++) begin
                    ctr = ((2 * i + 1) * 32768) / 340;
                    if (c == ctr) begin
                        if (i == 0)      start_ok = (c_tx === 1'b0);
                        else if (i == 9) stop_ok  = (c_tx === 1'b1);
                        else             rx[i - 1] = c_tx;
                    end
                end
                if (c_done === 1'b1) done_at = c;
                @(negedge clk);
            end
            tests++; if (rx !== bytes_v[k]) begin fails++; $display("FAIL loop_byte got %h want %h", rx, bytes_v[k]); end
            tests++; if (!start_ok || !stop_ok) begin fails++; $display("FAIL loop_framing byte=%h start_ok=%b stop_ok=%b want 11", bytes_v[k], start_ok, stop_ok); end
            tests++; if (done_at < 1925 || done_at > 1930) begin fails++; $display("FAIL loop_done_time byte=%h got %0d want 1925..1930", bytes_v[k], done_at); end
            tests++; if (c_ready !== 1'b1 || c_busy !== 1'b0) begin fails++; $display("FAIL loop_idle ready=%b busy=%b want 1 0", c_ready, c_busy); end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_frame(8'h55);
        test_back_to_back();
        test_reset_mid_frame();
        test_two_stop_bits();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- 8N1 UART transmitter; serialises bytes onto `tx`.
- Bit timing uses the same fractional-accumulator 16x oversample tick scheme as the UART receiver, so one ADDER value gives matching baud on both directions.
- Sits beside uart_receiver in the uart3 module set, fed by the host-side logic through a valid/ready byte handshake with one byte of holding buffer.

Parameters:
- BIT_DEPTH, 11, width of the baud phase accumulator.
- ADDER, 170, accumulator increment per clk. Tick rate = f_clk*ADDER/2^BIT_DEPTH. Legal range 1..2^BIT_DEPTH.
- OVERSAMPLE, 16, ticks per bit period.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous reset, active-high
- data  input  8  byte to send, sampled on accept
- send  input  1  valid; byte accepted on a clk edge where send && ready
- ready  output  1  high when the holding register is empty
- busy  output  1  high while a frame (start through last stop bit) is on the line
- done  output  1  one-clk pulse on the clk where the last stop bit period ends
- tx  output  1  serial line, idle high

Behaviour:
- Reset: acc=0, tick=0, state=IDLE, tx=1, ready=1, busy=0, done=0, holding register empty, shift register=0, counters=0. A reset mid-frame aborts the frame: tx=1 on the next edge, and any pending byte is discarded.
- Tick generator:
  - sum = acc + ADDER, computed BIT_DEPTH+1 bits wide.
  - acc <= sum[BIT_DEPTH-1:0]; tick <= sum[BIT_DEPTH].
  - Free-running; tick is a registered one-clk pulse.
  - With ADDER=2^BIT_DEPTH, tick=1 every clk after reset.
- Handshake:
  - Accept when send && ready: byte goes to the holding register, and ready drops on the following clk.
  - send while ready=0 is ignored; data is not captured.
- Holding-to-shift transfer: in IDLE, or at the end of the final stop bit, a full holding register loads the shift register and ready rises on the next clk. A byte is in flight and one more is queued when ready=0 and busy=1.
- States: IDLE, START, DATA, STOP. A sub-tick counter (0..OVERSAMPLE-1) and a bit index (0..7) advance only on tick. All transitions occur on a tick where the sub-tick counter is OVERSAMPLE-1, except IDLE->START.
  - IDLE: tx=1, busy=0. If the holding register is full, on the next tick go to START with the sub-tick counter at 0. This load tick counts as the first tick of the start bit.
  - START: tx=0 for OVERSAMPLE ticks, then DATA with bit index 0.
  - DATA: tx = shift[bit index], LSB first, for OVERSAMPLE ticks per bit. After bit 7 go to STOP.
  - STOP: tx=1 for STOP_BITS*OVERSAMPLE ticks. At the end, pulse done; then go to START if the holding register is full (no idle gap between frames), else IDLE.
- tx is registered and glitch-free. It changes only on clk edges coincident with tick or with reset.
- Simultaneous events:
  - Accept on the same edge the holding register empties into the shift register: the new byte is not accepted, because ready was 0 on that edge.
  - Accept in IDLE on the same clk as a tick: the frame starts on the next tick.
- Frame length = (10 + STOP_BITS - 1) * OVERSAMPLE ticks exactly. There is no drift beyond the accumulator's fractional jitter.

Test Plan:
- ADDER=2048, BIT_DEPTH=11 (tick every clk). Send 0x55 -> tx pattern, 16 clk per bit: 0 1 0 1 0 1 0 1 0 1; done pulses exactly once, 160 clk after the first low; busy high throughout.
- Back-to-back: send 0xA3, then 0x0F while ready=1 -> two frames with no idle high between the first stop bit and the second start bit; ready low until the second byte is transferred; done pulses twice.
- Third send while ready=0 -> data ignored; only two frames are transmitted.
- Reset asserted mid-DATA of 0xFF -> tx=1 on the next clk, ready=1, busy=0; no done pulse; a new send of 0x00 produces a clean full frame.
- Loopback with default ADDER=170 into uart_receiver (same ADDER): bytes 0x00, 0xFF, 0x81, 0x3C -> each received byte equals the sent byte.
- STOP_BITS=2, ADDER=2048: send 0x01 -> stop high for 32 clk before the next start or idle; frame length 176 clk.
